// File: rtl/decoder2x4_seq_if.sv
// Handshake and output bundle for decoder2x4_seq.
// master drives codes in; slave (the decoder) returns the one-hot word and status.
interface decoder2x4_seq_if;
    logic [1:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] qout;
    logic       qout_valid;
    logic       busy;

    modport master (
        output din, din_valid,
        input  din_ready, qout, qout_valid, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, qout, qout_valid, busy
    );
endinterface

// File: rtl/decoder2x4_seq.sv
// Sequenced 2-to-4 decoder: accepts a code, drives its one-hot word for HOLD_CYCLES, then GAP_CYCLES of zeros.
// Optional DECODER_SEQ_COUNT_EN adds an 8-bit wrapping acceptance counter output dec_count.
module decoder2x4_seq #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             reset,
    decoder2x4_seq_if.slave  bus
`ifdef DECODER_SEQ_COUNT_EN
    ,
    output logic [7:0]       dec_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam bit         HAS_GAP   = (GAP_CYCLES != 0);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [1:0] code_q,  code_d;

`ifdef DECODER_SEQ_COUNT_EN
    logic [7:0] count_q, count_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
`ifdef DECODER_SEQ_COUNT_EN
        count_d = count_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.din_valid) begin
                    code_d  = bus.din;
                    cnt_d   = HOLD_LOAD;
                    state_d = DRIVE;
`ifdef DECODER_SEQ_COUNT_EN
                    count_d = count_q + 8'd1;
`endif
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    if (HAS_GAP) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only registered state, so din never reaches qout combinationally.
    always_comb begin
        bus.din_ready  = (state_q == IDLE);
        bus.busy       = (state_q != IDLE);
        bus.qout_valid = (state_q == DRIVE);
        bus.qout       = (state_q == DRIVE) ? (4'b0001 << code_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
`ifdef DECODER_SEQ_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
`ifdef DECODER_SEQ_COUNT_EN
            count_q <= count_d;
`endif
        end
    end

`ifdef DECODER_SEQ_COUNT_EN
    assign dec_count = count_q;
`endif

endmodule

// File: tb/tb_decoder2x4_seq.sv
// Self-checking bench for decoder2x4_seq: default instance and a HOLD=1/GAP=0 instance share stimulus.
// Words are queued on acceptance and popped when the DUT raises qout_valid.
module tb_decoder2x4_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] din;
    logic       din_valid;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;

    always #5 clk = ~clk;

    decoder2x4_seq_if if0 ();
    decoder2x4_seq_if if1 ();

    assign if0.din       = din;
    assign if0.din_valid = din_valid;
    assign if1.din       = din;
    assign if1.din_valid = din_valid;

`ifdef DECODER_SEQ_COUNT_EN
    logic [7:0] dc0, dc1;
`endif

    decoder2x4_seq u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
`ifdef DECODER_SEQ_COUNT_EN
        ,
        .dec_count (dc0)
`endif
    );

    decoder2x4_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
`ifdef DECODER_SEQ_COUNT_EN
        ,
        .dec_count (dc1)
`endif
    );

    // Reference model: remaining drive and gap slots per instance.
    int unsigned m_hold [2] = '{4, 1};
    int unsigned m_gap  [2] = '{1, 0};
    int unsigned drive_left [2] = '{0, 0};
    int unsigned gap_left   [2] = '{0, 0};
    int          m_acc [2] = '{0, 0};
    bit          m_accepted [2] = '{0, 0};
    logic        prev_vld [2] = '{0, 0};
    logic [3:0]  cur_word [2] = '{4'd0, 4'd0};
    logic [3:0]  sb0 [$];
    logic [3:0]  sb1 [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input int k);
        logic [3:0] w;
        m_accepted[k] = 1'b0;
        if (reset) begin
            drive_left[k] = 0;
            gap_left[k]   = 0;
            m_acc[k]      = 0;
            if (k == 0) sb0.delete(); else sb1.delete();
        end else if (drive_left[k] == 0 && gap_left[k] == 0) begin
            if (din_valid) begin
                w = 4'b0001 << din;
                if (k == 0) sb0.push_back(w); else sb1.push_back(w);
                drive_left[k] = m_hold[k];
                gap_left[k]   = m_gap[k];
                m_acc[k]++;
                m_accepted[k] = 1'b1;
            end
        end else if (drive_left[k] != 0) begin
            drive_left[k]--;
        end else begin
            gap_left[k]--;
        end
    endtask

    task automatic check_dut(input int k, input logic rdy, input logic bsy, input logic vld,
                             input logic [3:0] q, input logic [7:0] dc);
        bit idle;
        idle = (drive_left[k] == 0 && gap_left[k] == 0);
        check($sformatf("d%0d.din_ready", k), rdy, idle);
        check($sformatf("d%0d.busy", k), bsy, !idle);
        check($sformatf("d%0d.qout_valid", k), vld, drive_left[k] != 0);
        check($sformatf("d%0d.onehot", k), $countones(q) <= 1, 1);
        if (vld && !prev_vld[k]) begin
            if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
                check($sformatf("d%0d.sb_underflow", k), 1, 0);
            end else begin
                cur_word[k] = (k == 0) ? sb0.pop_front() : sb1.pop_front();
            end
        end
        if (vld) check($sformatf("d%0d.qout", k), q, cur_word[k]);
        else     check($sformatf("d%0d.qout_zero", k), q, 4'd0);
        prev_vld[k] = vld;
`ifdef DECODER_SEQ_COUNT_EN
        check($sformatf("d%0d.dec_count", k), dc, 8'(m_acc[k]));
`else
        if (dc !== 8'd0) check("dc_tie", dc, 0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
`ifdef DECODER_SEQ_COUNT_EN
        check_dut(0, if0.din_ready, if0.busy, if0.qout_valid, if0.qout, dc0);
        check_dut(1, if1.din_ready, if1.busy, if1.qout_valid, if1.qout, dc1);
`else
        check_dut(0, if0.din_ready, if0.busy, if0.qout_valid, if0.qout, 8'd0);
        check_dut(1, if1.din_ready, if1.busy, if1.qout_valid, if1.qout, 8'd0);
`endif
    endtask

    initial begin
        int t_acc [4];
        int n_acc;
        reset = 1'b1; din = '0; din_valid = 1'b0;
        tick(); tick();
        check("rst.din_ready", if0.din_ready, 1);
        check("rst.qout", if0.qout, 4'd0);
        check("rst.qout_valid", if0.qout_valid, 0);
        check("rst.busy", if0.busy, 0);
        reset = 1'b0;
        tick();

        // Single code 2: four cycles of 0100, one gap cycle, then ready.
        din = 2'd2; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("r30.qout", if0.qout, 4'b0100);
            check("r30.valid", if0.qout_valid, 1);
            tick();
        end
        check("r30.gap_qout", if0.qout, 4'd0);
        check("r30.gap_busy", if0.busy, 1);
        tick();
        check("r30.ready", if0.din_ready, 1);

        // Back-to-back sweep of codes 0..3 with valid held high.
        din = 2'd0; din_valid = 1'b1; n_acc = 0;
        for (int c = 0; c < 40 && n_acc < 4; c++) begin
            tick();
            if (m_accepted[0]) begin
                t_acc[n_acc] = cyc;
                n_acc++;
                din = 2'(n_acc);
            end
        end
        din_valid = 1'b0;
        check("r31.accepts", n_acc, 4);
        for (int i = 1; i < 4; i++) check("r31.spacing", t_acc[i] - t_acc[i-1], 6);
        repeat (8) tick();

        // Input changes during DRIVE are ignored.
        din = 2'd1; din_valid = 1'b1;
        tick();
        din = 2'd3;
        for (int i = 0; i < 4; i++) begin
            check("r32.qout", if0.qout, 4'b0010);
            tick();
        end
        din_valid = 1'b0;
        repeat (4) tick();

        // Reset in the 2nd DRIVE cycle aborts the word.
        din = 2'd3; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        check("r33.qout_pre", if0.qout, 4'b1000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r33.qout", if0.qout, 4'd0);
        check("r33.valid", if0.qout_valid, 0);
        check("r33.busy", if0.busy, 0);
        check("r33.ready", if0.din_ready, 1);

        // Reset wins over a simultaneous acceptance.
        din = 2'd1; din_valid = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; din_valid = 1'b0;
        check("r26.busy", if0.busy, 0);
        tick();
        check("r26.valid", if0.qout_valid, 0);

        // HOLD=1, GAP=0 instance alternates 1,0,1,0 under continuous valid.
        din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 2'($urandom_range(0, 3));
            tick();
            check("r34.valid", if1.qout_valid, (i % 2 == 0) ? 1 : 0);
        end
        din_valid = 1'b0;
        repeat (6) tick();

        // Random traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            din       = 2'($urandom_range(0, 3));
            din_valid = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 40) == 0);
            tick();
        end
        reset = 1'b0; din_valid = 1'b0;
        repeat (8) tick();

`ifdef DECODER_SEQ_COUNT_EN
        reset = 1'b1; tick(); reset = 1'b0;
        din_valid = 1'b1;
        for (int c = 0; c < 257 * 6 + 20 && m_acc[0] < 257; c++) begin
            din = 2'($urandom_range(0, 3));
            tick();
        end
        din_valid = 1'b0;
        check("r35.accepts", m_acc[0], 257);
        check("r35.dec_count", dc0, 8'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("r35.dec_count_rst", dc0, 8'd0);
        repeat (8) tick();
`endif

        check("sb0.drained", sb0.size(), 0);
        check("sb1.drained", sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder2x4_seq.md
DECODER2X4_SEQ -- requirements
Module: decoder2x4_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, number of cycles a decoded one-hot word is driven; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 1, number of all-zero cycles after each hold; legal range 0..255.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 din  input  2  binary code to decode: 0..3.
REQ-007 din_valid  input  1  din holds a code to be accepted.
REQ-008 din_ready  output  1  block can accept a code this cycle.
REQ-009 qout  output  4  one-hot decoded word; bit n high for code n.
REQ-010 qout_valid  output  1  qout carries a decoded word this cycle.
REQ-011 busy  output  1  high in DRIVE or GAP.

Function
REQ-012 States SHALL be IDLE, DRIVE and GAP, held in a registered state variable.
REQ-013 IDLE: din_ready=1, qout=0, qout_valid=0, busy=0.
REQ-014 Handshake: a code is accepted on an edge where din_valid=1 and din_ready=1; no other condition accepts it.
REQ-015 On acceptance, din SHALL be captured into an internal 2-bit register, hold counter loaded with HOLD_CYCLES-1, state -> DRIVE.
REQ-016 DRIVE: qout = 4'b0001 shifted left by the captured code, qout_valid=1, din_ready=0, busy=1.
REQ-017 Latency: qout_valid rises on the first edge after acceptance; it stays high for exactly HOLD_CYCLES consecutive cycles.
REQ-018 DRIVE: counter decrements each cycle; when it is 0 -> GAP, with the counter loaded to GAP_CYCLES-1, if GAP_CYCLES>0; otherwise -> IDLE.
REQ-019 GAP: qout=0, qout_valid=0, din_ready=0, busy=1; counter decrements; when it is 0 -> IDLE.
REQ-020 Changes on din/din_valid while not in IDLE SHALL be ignored and SHALL NOT alter the driven word.
REQ-021 When GAP_CYCLES=0, the minimum spacing between acceptances is HOLD_CYCLES+1 cycles, because of the single IDLE cycle.
REQ-022 qout SHALL never have more than one bit set in any cycle.
REQ-023 All outputs SHALL be register-driven or decoded only from registered state; no combinational path from din to qout.

Reset
REQ-024 reset=1 at an edge SHALL force: state=IDLE, counter=0, captured code=0, qout=0, qout_valid=0, busy=0, din_ready=1 after that edge.
REQ-025 Reset asserted in DRIVE or GAP SHALL abort the word; no remaining hold or gap cycles are issued.
REQ-026 reset has priority over an acceptance on the same edge; that code is discarded.

Configuration
REQ-027 Macro DECODER_SEQ_COUNT_EN, when defined, SHALL add output dec_count (8 bits), incremented on every acceptance and wrapping 255 -> 0.
REQ-028 dec_count SHALL clear to 0 on reset.
REQ-029 Without DECODER_SEQ_COUNT_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then din=2'b10 with din_valid=1 for 1 cycle -> qout=4'b0100 with qout_valid=1 for 4 cycles, then qout=0 busy=1 for 1 cycle, then din_ready=1.
REQ-031 Sweep codes 0..3 back-to-back with din_valid held high -> qout sequence 0001, 0010, 0100, 1000, each for 4 cycles; acceptances 6 cycles apart.
REQ-032 During DRIVE of code 1, change din to 3 with din_valid=1 -> qout stays 4'b0010 for the full hold.
REQ-033 Assert reset on the 2nd DRIVE cycle of code 3 -> next cycle qout=0, qout_valid=0, busy=0, din_ready=1.
REQ-034 HOLD_CYCLES=1, GAP_CYCLES=0, with continuous valid codes -> one-hot output every other cycle; qout_valid pattern 1,0,1,0.
REQ-035 With DECODER_SEQ_COUNT_EN defined, 257 acceptances -> dec_count=1; after reset, dec_count=0.
